// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the CPU-readable UART receiver: receiver FSM state
// encoding, STATUS register bit positions, register addresses, the
// oversampling ratio, the mid-bit sample tick numbers and a majority-vote
// helper.
// ----------------------------------------------------------------------------
package uart_pkg;

    // Receiver FSM states with fixed encodings.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rxState_t;

    // STATUS register bit positions.
    localparam int STAT_RX_READY  = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_FULL      = 3;
    localparam int STAT_BUSY      = 4;

    // Register addresses seen on the one-bit address input.
    localparam logic REG_RXDATA = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // Ticks per bit time.
    localparam int OVERSAMPLE = 16;

    // Tick numbers (1-based within a bit) used for the 3-sample vote.
    localparam logic [3:0] SAMPLE_TICK_A = 4'd7;
    localparam logic [3:0] SAMPLE_TICK_B = 4'd8;
    localparam logic [3:0] SAMPLE_TICK_C = 4'd9;

    // Two-out-of-three majority vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Small receive FIFO. Pointers carry one extra wrap bit so full and empty
// fall out of a plain compare. A push on a full FIFO is accepted only when a
// pop happens in the same clock.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset (clears the pointers)
//   i_push       write request
//   i_pushData   byte to write
//   i_pop        read request (ignored while empty)
//   o_head       entry at the read pointer (only meaningful while non-empty)
//   o_full       FIFO holds DEPTH entries
//   o_empty      FIFO holds no entries
//   o_emptyNext  FIFO will be empty after this clock edge
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_emptyNext
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic        w_doPush;
    logic        w_doPop;
    logic [AW:0] w_wrNext;
    logic [AW:0] w_rdNext;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

    // A full FIFO still accepts a push if the head leaves in the same clock.
    assign w_doPush = i_push && (!o_full || i_pop);
    assign w_doPop  = i_pop && !o_empty;

    assign w_wrNext    = r_wrPtr + (AW+1)'(w_doPush);
    assign w_rdNext    = r_rdPtr + (AW+1)'(w_doPop);
    assign o_emptyNext = (w_wrNext == w_rdNext);

    assign o_head = r_mem[r_rdPtr[AW-1:0]];

    // Pointer registers; they wrap naturally through the extra MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            r_wrPtr <= w_wrNext;
            r_rdPtr <= w_rdNext;
        end
    end

    // Storage needs no reset; an entry is only read after it was written.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// ----------------------------------------------------------------------------
// uart_rx_port
// 6502-bus UART receiver. Synchronizes the serial line, oversamples it at
// 16x the baud rate, deframes 8N1 characters and queues them in a FIFO.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_addr      register select: 0 = RXDATA, 1 = STATUS
//   i_cs        chip select
//   i_rd_en     one-clock read strobe; side effects need i_cs && i_rd_en
//   o_data_out  combinational read data for the selected register
//   i_rx        asynchronous serial input, idles high
//   o_irq       high while received data is pending
// ----------------------------------------------------------------------------
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_addr,
    input  logic       i_cs,
    input  logic       i_rd_en,
    output logic [7:0] o_data_out,
    input  logic       i_rx,
    output logic       o_irq
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_TICK = 4'(OVERSAMPLE - 1);

    rxState_t         r_state;
    rxState_t         w_stateNext;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rxsPrev;
    logic [DIV_W-1:0] r_divCnt;
    logic [3:0]       r_tickCnt;
    logic [3:0]       w_tickCntNext;
    logic [2:0]       r_bitIdx;
    logic [2:0]       w_bitIdxNext;
    logic [7:0]       r_shift;
    logic [7:0]       w_shiftNext;
    logic             r_sampA;
    logic             w_sampANext;
    logic             r_sampB;
    logic             w_sampBNext;
    logic             r_overrun;
    logic             r_frameErr;
    logic             r_irq;

    logic       w_rxs;
    logic       w_startEdge;
    logic       w_tick;
    logic       w_vote;
    logic       w_push;
    logic       w_setFrameErr;
    logic       w_popReq;
    logic       w_statRead;
    logic       w_overrunSet;
    logic [7:0] w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_emptyNext;

    assign w_rxs       = r_sync2;
    assign w_startEdge = (r_state == ST_IDLE) && r_rxsPrev && !w_rxs;
    assign w_tick      = (r_divCnt == DIV_LAST);
    assign w_vote      = majority3(r_sampA, r_sampB, w_rxs);
    assign w_popReq    = i_cs && i_rd_en && (i_addr == REG_RXDATA);
    assign w_statRead  = i_cs && i_rd_en && (i_addr == REG_STATUS);
    assign w_overrunSet = w_push && w_full && !w_popReq;

    // Two-flop synchronizer plus the delayed copy used for edge detection.
    // Resetting to 1 matches the idle line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rxsPrev <= 1'b1;
        end else begin
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            r_rxsPrev <= r_sync2;
        end
    end

    // Free-running 16x tick divider, re-phased on a start edge so tick n
    // lands n/16 of a bit after the falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_divCnt <= '0;
        end else if (w_startEdge || w_tick) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
        end
    end

    // Receiver FSM state and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_tickCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_sampA   <= 1'b1;
            r_sampB   <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_tickCnt <= w_tickCntNext;
            r_bitIdx  <= w_bitIdxNext;
            r_shift   <= w_shiftNext;
            r_sampA   <= w_sampANext;
            r_sampB   <= w_sampBNext;
        end
    end

    // Next-state logic. r_tickCnt holds how many ticks of the current bit
    // have passed, so 1-based tick n is handled while r_tickCnt == n-1 and
    // the counter wraps to 0 on the 16th tick. START runs the whole start
    // bit (validating it at tick 8) so that DATA's count starts on a bit
    // boundary and ticks 7/8/9 straddle the middle of every data bit.
    always_comb begin
        w_stateNext   = r_state;
        w_tickCntNext = r_tickCnt;
        w_bitIdxNext  = r_bitIdx;
        w_shiftNext   = r_shift;
        w_sampANext   = r_sampA;
        w_sampBNext   = r_sampB;
        w_push        = 1'b0;
        w_setFrameErr = 1'b0;

        if (w_tick && (r_state == ST_START || r_state == ST_DATA || r_state == ST_STOP)) begin
            w_tickCntNext = r_tickCnt + 4'd1;
            if (r_tickCnt == SAMPLE_TICK_A - 4'd1) begin
                w_sampANext = w_rxs;
            end
            if (r_tickCnt == SAMPLE_TICK_B - 4'd1) begin
                w_sampBNext = w_rxs;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_startEdge) begin
                    w_stateNext   = ST_START;
                    w_tickCntNext = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if ((r_tickCnt == SAMPLE_TICK_B - 4'd1) && w_rxs) begin
                        w_stateNext = ST_IDLE;
                    end else if (r_tickCnt == LAST_TICK) begin
                        w_stateNext  = ST_DATA;
                        w_bitIdxNext = '0;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_tickCnt == SAMPLE_TICK_C - 4'd1) begin
                        w_shiftNext = {w_vote, r_shift[7:1]};
                    end
                    if (r_tickCnt == LAST_TICK) begin
                        if (r_bitIdx == 3'd7) begin
                            w_stateNext = ST_STOP;
                        end else begin
                            w_bitIdxNext = r_bitIdx + 3'd1;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (w_tick && (r_tickCnt == SAMPLE_TICK_C - 4'd1)) begin
                    if (w_vote) begin
                        w_push      = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_setFrameErr = 1'b1;
                        w_stateNext   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rxs) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_pushData  (r_shift),
        .i_pop       (w_popReq),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_emptyNext (w_emptyNext)
    );

    // Sticky error flags, cleared by a STATUS read; a new error in the same
    // clock as the read wins. irq follows the post-edge FIFO occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_overrunSet) begin
                r_overrun <= 1'b1;
            end else if (w_statRead) begin
                r_overrun <= 1'b0;
            end
            if (w_setFrameErr) begin
                r_frameErr <= 1'b1;
            end else if (w_statRead) begin
                r_frameErr <= 1'b0;
            end
            r_irq <= !w_emptyNext;
        end
    end

    assign o_irq = r_irq;

    // Combinational register read mux.
    always_comb begin
        o_data_out = 8'h00;
        if (i_addr == REG_STATUS) begin
            o_data_out[STAT_RX_READY]  = !w_empty;
            o_data_out[STAT_OVERRUN]   = r_overrun;
            o_data_out[STAT_FRAME_ERR] = r_frameErr;
            o_data_out[STAT_FULL]      = w_full;
            o_data_out[STAT_BUSY]      = (r_state != ST_IDLE);
        end else if (!w_empty) begin
            o_data_out = w_head;
        end
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_port
// Self-checking bench for uart_rx_port. The clock/baud ratio is scaled down
// (divisor 5, 80 clocks per bit) so every scenario fits a short run. A
// queue-based model of the receive FIFO and sticky flags supplies every
// expected register value.
// ----------------------------------------------------------------------------
module tb_uart_rx_port;

    localparam int CLK_FREQ   = 800_000;
    localparam int BAUD_RATE  = 9600;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = CLK_FREQ / (BAUD_RATE * 16);
    localparam int BIT_CLKS   = DIV * 16;

    logic       clk = 1'b0;
    logic       rstN;
    logic       addr;
    logic       cs;
    logic       rdEn;
    logic       rx;
    logic       irq;
    logic [7:0] dataOut;

    int testCount    = 0;
    int failCount    = 0;
    int cycleCount   = 0;
    int startCycle   = 0;
    int irqRiseCycle = 0;
    int latency      = 0;
    logic irqPrev    = 1'b0;

    logic [7:0] modelQ [$];
    bit         mOverrun  = 1'b0;
    bit         mFrameErr = 1'b0;

    uart_rx_port #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_addr     (addr),
        .i_cs       (cs),
        .i_rd_en    (rdEn),
        .o_data_out (dataOut),
        .i_rx       (rx),
        .o_irq      (irq)
    );

    // 25 MHz-style clock: 40 time units per period.
    always #20 clk = ~clk;

    // Count active edges so stimulus can be timed in clocks.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Remember the clock on which irq last rose.
    always @(negedge clk) begin
        if (irq === 1'b1 && irqPrev === 1'b0) begin
            irqRiseCycle <= cycleCount;
        end
        irqPrev <= irq;
    end

    // Count a comparison and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected STATUS value from the model.
    function automatic logic [7:0] expStatus(input bit busy);
        return {3'b000, busy, (modelQ.size() == FIFO_DEPTH), mFrameErr, mOverrun, (modelQ.size() != 0)};
    endfunction

    // A received byte either enters the model FIFO or is lost as an overrun.
    task automatic modelReceive(input logic [7:0] b);
        if (modelQ.size() == FIFO_DEPTH) begin
            mOverrun = 1'b1;
        end else begin
            modelQ.push_back(b);
        end
    endtask

    // One-clock register read strobe; data is sampled mid-strobe.
    task automatic readReg(input logic a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        cs   = 1'b1;
        rdEn = 1'b1;
        #1 d = dataOut;
        @(negedge clk);
        cs   = 1'b0;
        rdEn = 1'b0;
        addr = 1'b0;
    endtask

    // Read STATUS and compare; the read clears the model's sticky flags.
    task automatic checkStatus(input string tag, input bit busy);
        logic [7:0] d;
        logic [7:0] e;
        e = expStatus(busy);
        readReg(1'b1, d);
        checkOutput(tag, 32'(d), 32'(e));
        mOverrun  = 1'b0;
        mFrameErr = 1'b0;
    endtask

    // Read RXDATA and compare against the model head, then pop the model.
    task automatic checkRxData(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        e = (modelQ.size() != 0) ? modelQ[0] : 8'h00;
        readReg(1'b0, d);
        checkOutput(tag, 32'(d), 32'(e));
        if (modelQ.size() != 0) begin
            void'(modelQ.pop_front());
        end
    endtask

    // Drive the first nBits bit times of an 8N1 frame (start, LSB-first data,
    // stop). A complete frame updates the model.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int nBits);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        @(negedge clk);
        startCycle = cycleCount;
        for (int i = 0; i < nBits; i++) begin
            rx = frame[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (nBits == 10) begin
            if (stopBit) begin
                modelReceive(data);
            end else begin
                mFrameErr = 1'b1;
            end
        end
    endtask

    // Main sequence.
    initial begin
        logic [7:0] b;
        logic [7:0] d;
        logic [7:0] e;
        int nReads;

        rstN = 1'b0;
        rx   = 1'b1;
        addr = 1'b0;
        cs   = 1'b0;
        rdEn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetIrq", 32'(irq), 32'(0));
        checkOutput("resetRxData", 32'(dataOut), 32'(0));
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        checkStatus("resetStatus", 1'b0);

        // Single byte and its latency of roughly 9.5 bit times.
        applyStimulus(8'h58, 1'b1, 10);
        latency = irqRiseCycle - startCycle;
        checkOutput("irqLatencyHalfBits", 32'((latency + BIT_CLKS / 4) / (BIT_CLKS / 2)), 32'(19));
        checkOutput("irqAfterByte", 32'(irq), 32'(1));
        checkStatus("singleStatus", 1'b0);
        checkRxData("singleData");
        repeat (2) @(negedge clk);
        checkOutput("irqAfterPop", 32'(irq), 32'(0));
        checkStatus("singleStatusEmpty", 1'b0);

        // Short glitch shorter than half a bit is rejected as a false start.
        @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        checkStatus("glitchBusy", 1'b1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkStatus("glitchIdle", 1'b0);
        checkOutput("glitchIrq", 32'(irq), 32'(0));

        // Overrun: five bytes without reads.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, 10);
        end
        checkStatus("overrunStatus", 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkRxData("overrunData");
        end
        checkStatus("overrunCleared", 1'b0);

        // Framing error followed by a long break: only one frame_err.
        applyStimulus(8'h55, 1'b0, 10);
        repeat (5 * BIT_CLKS) @(negedge clk);
        checkStatus("breakStatus", 1'b1);
        repeat (15 * BIT_CLKS) @(negedge clk);
        checkStatus("breakNoRepeat", 1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        checkStatus("breakReleased", 1'b0);
        checkOutput("breakIrq", 32'(irq), 32'(0));
        applyStimulus(8'hA5, 1'b1, 10);
        checkRxData("afterBreakData");

        // Push/pop collision on a full FIFO.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1, 10);
        end
        b = 8'($urandom_range(0, 255));
        fork
            applyStimulus(b, 1'b1, 10);
            begin
                @(negedge clk);
                repeat (latency - 1) @(negedge clk);
                e = modelQ[0];
                addr = 1'b0;
                cs   = 1'b1;
                rdEn = 1'b1;
                #1 d = dataOut;
                checkOutput("collisionData", 32'(d), 32'(e));
                void'(modelQ.pop_front());
                @(negedge clk);
                cs   = 1'b0;
                rdEn = 1'b0;
            end
        join
        checkStatus("collisionStatus", 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkRxData("collisionOrder");
        end

        // Async reset during data bit 3 with a byte already pending.
        applyStimulus(8'($urandom_range(0, 255)), 1'b1, 10);
        b = 8'($urandom_range(0, 255));
        applyStimulus(b, 1'b1, 4);
        rx = b[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rstN = 1'b0;
        rx   = 1'b1;
        addr = 1'b0;
        #1;
        checkOutput("midResetIrq", 32'(irq), 32'(0));
        checkOutput("midResetRxData", 32'(dataOut), 32'(0));
        addr = 1'b1;
        #1;
        checkOutput("midResetStatus", 32'(dataOut), 32'(0));
        addr = 1'b0;
        modelQ.delete();
        mOverrun  = 1'b0;
        mFrameErr = 1'b0;
        repeat (5) @(negedge clk);
        rstN = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkStatus("postResetStatus", 1'b0);
        applyStimulus(8'hC3, 1'b1, 10);
        checkRxData("postResetData");

        // Random traffic with random read patterns.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1, 10);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            nReads = int'($urandom_range(0, 2));
            for (int r = 0; r < nReads; r++) begin
                checkRxData("randomData");
            end
            if ($urandom_range(0, 3) == 0) begin
                checkStatus("randomStatus", 1'b0);
            end
        end
        checkStatus("randomFinalStatus", 1'b0);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            checkRxData("randomDrain");
        end
        checkStatus("randomEmpty", 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
